// File: rtl/serialtx_arb.sv
`default_nettype none
// ============================================================================
// Module   : serialtx_arb
// Purpose  : Round-robin arbiter sharing one serial transmitter between NREQ
//            byte-stream requesters. Acts as the single pipelined-Wishbone
//            master of the transmitter: latches the granted byte, issues one
//            write, waits for the ack, then re-arbitrates.
// Ports    : clk, rst_n (sync, active-low)
//            req_valid/req_data/req_last in, req_ready out (per requester)
//            wb_cyc/wb_stb/wb_we/wb_addr/wb_data_w out, wb_ack/wb_stall in
//            grant_id (last accepted requester), busy (FSM not idle)
// Options  : `define SERIALTX_ARB_PKTLOCK_EN to keep a packet (bytes up to and
//            including req_last=1) from one requester together on the line.
// Revision : 1.0 - initial release
// ============================================================================
module serialtx_arb #(
  parameter int  NREQ  = 4,
  parameter int  FRAME = 8,
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*FRAME-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [31:0]           wb_addr,
  output logic [FRAME-1:0]      wb_data_w,
  input  logic                  wb_ack,
  input  logic                  wb_stall,
  output logic [IW-1:0]         grant_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state_q;
  logic             cyc_q;
  logic             stb_q;
  logic             busy_q;
  logic [FRAME-1:0] data_q;
  logic [IW-1:0]    grant_id_q;

  logic [NREQ-1:0]  w_elig;
  logic             w_found;
  logic [IW-1:0]    w_idx;
  int unsigned      w_cand;

`ifdef SERIALTX_ARB_PKTLOCK_EN
  // While a packet is in progress only its owner (the last granted index)
  // may be served.
  logic lock_q;
  assign w_elig = lock_q ? (req_valid & (NREQ'(1) << grant_id_q)) : req_valid;
`else
  logic w_unused_last;
  assign w_unused_last = ^req_last;
  assign w_elig        = req_valid;
`endif

  // Search upward from the requester after the last grant, wrapping at NREQ.
  // The explicit subtract keeps the wrap correct for non-power-of-2 NREQ.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = 32'(grant_id_q) + 32'(k) + 32'd1;
      if (w_cand >= 32'(NREQ)) begin
        w_cand = w_cand - 32'(NREQ);
      end
      if (!w_found && w_elig[w_cand[IW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_cand[IW-1:0];
      end
    end
  end

  // Ready depends only on state and requester inputs, never on wb_* inputs.
  // Gated by rst_n so nothing is accepted while reset is held.
  assign req_ready = (rst_n && (state_q == S_IDLE) && w_found)
                   ? (NREQ'(1) << w_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      grant_id_q <= IW'(NREQ - 1);
`ifdef SERIALTX_ARB_PKTLOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_found) begin
            data_q     <= req_data[w_idx*FRAME +: FRAME];
            grant_id_q <= w_idx;
            state_q    <= S_REQ;
            cyc_q      <= 1'b1;
            stb_q      <= 1'b1;
            busy_q     <= 1'b1;
`ifdef SERIALTX_ARB_PKTLOCK_EN
            lock_q     <= !req_last[w_idx];
`endif
          end
        end
        S_REQ: begin
          // Hold the strobe and data for as long as the slave stalls.
          if (!wb_stall) begin
            state_q <= S_WAIT;
            stb_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (wb_ack) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wb_cyc    = cyc_q;
  assign wb_stb    = stb_q;
  assign wb_we     = stb_q;
  assign wb_addr   = 32'd0;
  assign wb_data_w = data_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_serialtx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_serialtx_arb
// Purpose  : Directed self-checking bench for serialtx_arb (NREQ=4, FRAME=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serialtx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr;
  logic [7:0]  wb_data_w;
  logic        wb_ack;
  logic        wb_stall;
  logic [1:0]  grant_id;
  logic        busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit ack_en   = 1'b1;
  bit take;

  serialtx_arb #(.NREQ(4), .FRAME(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data_w (wb_data_w),
    .wb_ack    (wb_ack),
    .wb_stall  (wb_stall),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Slave: a strobe seen without stall is acknowledged in the following cycle.
  initial begin
    wb_ack = 1'b0;
    forever begin
      @(negedge clk);
      take = wb_stb && !wb_stall && ack_en;
      @(posedge clk);
      #1;
      wb_ack = take;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    wb_stall  = 1'b0;
    ack_en    = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'h0;
    req_last  = 4'h0;
    wb_stall  = 1'b0;
    tick();
    tick();
    chk_cnt++; if (wb_cyc !== 1'b0) $display("FAIL reset_cyc got %b exp 0", wb_cyc); else pass_cnt++;
    chk_cnt++; if (wb_stb !== 1'b0) $display("FAIL reset_stb got %b exp 0", wb_stb); else pass_cnt++;
    chk_cnt++; if (wb_we !== 1'b0) $display("FAIL reset_we got %b exp 0", wb_we); else pass_cnt++;
    chk_cnt++; if (wb_addr !== 32'h0) $display("FAIL reset_addr got %h exp 0", wb_addr); else pass_cnt++;
    chk_cnt++; if (wb_data_w !== 8'h00) $display("FAIL reset_data got %h exp 00", wb_data_w); else pass_cnt++;
    chk_cnt++; if (grant_id !== 2'd3) $display("FAIL reset_grant got %0d exp 3", grant_id); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (req_ready !== 4'h0) $display("FAIL reset_ready got %b exp 0000", req_ready); else pass_cnt++;
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  task automatic test_single();
    req_valid      = 4'b0001;
    req_data[7:0]  = 8'h55;
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_ready_t got %b exp 0001", req_ready); else pass_cnt++;
    tick();
    req_valid = '0;
    chk_cnt++; if (wb_stb !== 1'b1 || wb_cyc !== 1'b1) $display("FAIL single_stb_t1 got stb=%b cyc=%b exp 1 1", wb_stb, wb_cyc); else pass_cnt++;
    chk_cnt++; if (wb_we !== 1'b1) $display("FAIL single_we_t1 got %b exp 1", wb_we); else pass_cnt++;
    chk_cnt++; if (wb_data_w !== 8'h55) $display("FAIL single_data_t1 got %h exp 55", wb_data_w); else pass_cnt++;
    chk_cnt++; if (grant_id !== 2'd0) $display("FAIL single_grant got %0d exp 0", grant_id); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL single_busy_t1 got %b exp 1", busy); else pass_cnt++;
    tick();
    chk_cnt++; if (wb_ack !== 1'b1) $display("FAIL single_ack_t2 got %b exp 1", wb_ack); else pass_cnt++;
    chk_cnt++; if (wb_stb !== 1'b0 || wb_cyc !== 1'b1) $display("FAIL single_wait_t2 got stb=%b cyc=%b exp 0 1", wb_stb, wb_cyc); else pass_cnt++;
    tick();
    chk_cnt++; if (busy !== 1'b0 || wb_cyc !== 1'b0) $display("FAIL single_idle_t3 got busy=%b cyc=%b exp 0 0", busy, wb_cyc); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int w;
    reset_dut();
    req_data  = 32'hA3A2A1A0;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (wb_stb !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      if (k == 4) req_valid = '0;
      chk_cnt++; if (wb_data_w !== 8'hA0 + 8'(k % 4)) $display("FAIL rr_data[%0d] got %h exp %h", k, wb_data_w, 8'hA0 + 8'(k % 4)); else pass_cnt++;
      chk_cnt++; if (grant_id !== 2'(k % 4)) $display("FAIL rr_grant[%0d] got %0d exp %0d", k, grant_id, k % 4); else pass_cnt++;
      tick();
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_stall();
    int acks;
    acks          = 0;
    req_data[7:0] = 8'h3C;
    req_valid     = 4'b0001;
    wb_stall      = 1'b1;
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL stall_ready_t got %b exp 0001", req_ready); else pass_cnt++;
    tick();
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk_cnt++; if (wb_stb !== 1'b1 || wb_data_w !== 8'h3C) $display("FAIL stall_hold[%0d] got stb=%b data=%h exp 1 3c", k, wb_stb, wb_data_w); else pass_cnt++;
      chk_cnt++; if (req_ready !== 4'h0) $display("FAIL stall_ready[%0d] got %b exp 0000", k, req_ready); else pass_cnt++;
      if (wb_ack === 1'b1) acks++;
      if (k == 5) wb_stall = 1'b0;
      tick();
    end
    chk_cnt++; if (wb_stb !== 1'b0 || wb_cyc !== 1'b1) $display("FAIL stall_end got stb=%b cyc=%b exp 0 1", wb_stb, wb_cyc); else pass_cnt++;
    if (wb_ack === 1'b1) acks++;
    req_valid = '0;
    tick();
    if (wb_ack === 1'b1) acks++;
    chk_cnt++; if (acks != 1) $display("FAIL stall_acks got %0d exp 1", acks); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL stall_idle got busy=%b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    ack_en         = 1'b0;
    req_data[15:8] = 8'h11;
    req_data[7:0]  = 8'h22;
    req_data[23:16]= 8'h33;
    req_valid      = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    tick();
    chk_cnt++; if (busy !== 1'b1 || wb_cyc !== 1'b1 || wb_stb !== 1'b0 || grant_id !== 2'd1) $display("FAIL mid_wait got busy=%b cyc=%b stb=%b gid=%0d exp 1 1 0 1", busy, wb_cyc, wb_stb, grant_id); else pass_cnt++;
    rst_n     = 1'b0;
    req_valid = 4'b0101;
    tick();
    chk_cnt++; if (wb_cyc !== 1'b0 || busy !== 1'b0) $display("FAIL mid_cyc got cyc=%b busy=%b exp 0 0", wb_cyc, busy); else pass_cnt++;
    chk_cnt++; if (grant_id !== 2'd3) $display("FAIL mid_grant got %0d exp 3", grant_id); else pass_cnt++;
    chk_cnt++; if (req_ready !== 4'h0) $display("FAIL mid_ready_rst got %b exp 0000", req_ready); else pass_cnt++;
    rst_n  = 1'b1;
    ack_en = 1'b1;
    #1;
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL mid_ready_after got %b exp 0001", req_ready); else pass_cnt++;
    tick();
    req_valid = '0;
    chk_cnt++; if (wb_data_w !== 8'h22 || grant_id !== 2'd0) $display("FAIL mid_next got data=%h gid=%0d exp 22 0", wb_data_w, grant_id); else pass_cnt++;
    tick();
    tick();
    tick();
  endtask

  task automatic test_pktlock();
    int n1, n2, seen;
    int ord [5];
    int exp_ord [5];
`ifdef SERIALTX_ARB_PKTLOCK_EN
    exp_ord = '{1, 1, 1, 2, 2};
`else
    exp_ord = '{1, 2, 1, 2, 1};
`endif
    ord = '{0, 0, 0, 0, 0};
    reset_dut();
    n1   = 0;
    n2   = 0;
    seen = 0;
    for (int c = 0; c < 80 && seen < 5; c++) begin
      req_valid        = {1'b0, (n2 < 2), (n1 < 3), 1'b0};
      req_data[15:8]   = 8'hB0 + 8'(n1);
      req_data[23:16]  = 8'hC0 + 8'(n2);
      req_last         = {1'b0, 1'b1, (n1 == 2), 1'b0};
      #1;
      if (req_ready[1] && req_valid[1]) begin
        ord[seen] = 1;
        seen++;
        n1++;
      end else if (req_ready[2] && req_valid[2]) begin
        ord[seen] = 2;
        seen++;
        n2++;
      end
      tick();
    end
    req_valid = '0;
    chk_cnt++; if (seen != 5) $display("FAIL pkt_timeout got %0d grants exp 5", seen); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      chk_cnt++; if (ord[i] != exp_ord[i]) $display("FAIL pkt_order[%0d] got %0d exp %0d", i, ord[i], exp_ord[i]); else pass_cnt++;
    end
    tick();
    tick();
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    wb_stall  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_pktlock();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
